// File: rtl/eight_bit_isa_pkg.sv
// Shared ISA definitions for the 8-bit machine: instruction field layout,
// opcode constants, the execute-strobe bundle and the sequencer state type.
// Used by the sequencer, its decoder and the ROM image tooling.
package eight_bit_isa_pkg;

    // Instruction layout: [7:4] opcode, [3:2] ra, [1:0] rb
    localparam int unsigned InstrW = 8;
    localparam int unsigned OpW    = 4;
    localparam int unsigned RegW   = 2;
    localparam int unsigned ProgW  = 2;

    localparam int unsigned OpHi = 7;
    localparam int unsigned OpLo = 4;
    localparam int unsigned RaHi = 3;
    localparam int unsigned RaLo = 2;
    localparam int unsigned RbHi = 1;
    localparam int unsigned RbLo = 0;

    // ALU-class opcodes
    localparam logic [OpW-1:0] OpAdd  = 4'h0;
    localparam logic [OpW-1:0] OpSub  = 4'h1;
    localparam logic [OpW-1:0] OpAnd  = 4'h2;
    localparam logic [OpW-1:0] OpOr   = 4'h3;
    localparam logic [OpW-1:0] OpXor  = 4'h4;
    localparam logic [OpW-1:0] OpShl  = 4'h5;
    localparam logic [OpW-1:0] OpSqa  = 4'h6;
    localparam logic [OpW-1:0] OpSqb  = 4'h7;
    localparam logic [OpW-1:0] OpShr  = 4'hC;
    localparam logic [OpW-1:0] OpBshr = 4'hD;

    // Datapath-control opcodes
    localparam logic [OpW-1:0] OpPush = 4'h8;
    localparam logic [OpW-1:0] OpLda  = 4'h9;
    localparam logic [OpW-1:0] OpLdb  = 4'hA;
    localparam logic [OpW-1:0] OpOut  = 4'hB;

    // One-hot execute strobes; at most one field is ever set
    typedef struct packed {
        logic alu;
        logic load_a;
        logic load_b;
        logic push;
        logic out;
    } strobes_t;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StDone
    } state_e;

    function automatic logic [OpW-1:0] opcode_of(input logic [InstrW-1:0] ir);
        return ir[OpHi:OpLo];
    endfunction

endpackage

// File: rtl/eight_bit_decoder.sv
// Combinational instruction decoder: maps an instruction word to its one-hot
// execute strobe and flags the two reserved opcodes as illegal.
//   ir      : instruction word
//   strobes : one-hot execute strobe (all zero for illegal opcodes)
//   illegal : opcode 1110 or 1111
module eight_bit_decoder
    import eight_bit_isa_pkg::*;
(
    input  logic [InstrW-1:0] ir,
    output strobes_t          strobes,
    output logic              illegal
);

    always_comb begin
        strobes = '0;
        illegal = 1'b0;
        case (opcode_of(ir))
            OpAdd, OpSub, OpAnd, OpOr, OpXor,
            OpShl, OpSqa, OpSqb, OpShr, OpBshr: strobes.alu    = 1'b1;
            OpPush:                             strobes.push   = 1'b1;
            OpLda:                              strobes.load_a = 1'b1;
            OpLdb:                              strobes.load_b = 1'b1;
            OpOut:                              strobes.out    = 1'b1;
            default:                            illegal        = 1'b1;
        endcase
    end

endmodule

// File: rtl/eight_bit_sequencer.sv
// Instruction fetch/decode controller for the 8-bit machine. Runs one program
// from address 0 until its `out` instruction, three cycles per instruction
// (FETCH, DECODE, EXEC), stalling in EXEC while the datapath is not ready.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start, prog_sel : begin a run of program prog_sel (accepted only in IDLE)
//   prog, address   : ROM select and fetch address
//   instruction     : ROM data for prog/address
//   exec_ready      : datapath accepts the current EXEC operation
//   alu_en .. out_en: one-hot execute strobes, high only in EXEC
//   alu_op, ra, rb  : opcode and register fields of the current instruction
//   busy, done      : not idle / one-cycle normal-completion pulse
//   error           : sticky illegal-opcode or address-overrun flag
//   instr_count     : instructions retired this run, saturating
module eight_bit_sequencer
    import eight_bit_isa_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned LAST_ADDR = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ProgW-1:0]  prog_sel,
    output logic [ProgW-1:0]  prog,
    output logic [ADDR_W-1:0] address,
    input  logic [InstrW-1:0] instruction,
    input  logic              exec_ready,
    output logic              alu_en,
    output logic [OpW-1:0]    alu_op,
    output logic [RegW-1:0]   ra,
    output logic [RegW-1:0]   rb,
    output logic              load_a_en,
    output logic              load_b_en,
    output logic              push_en,
    output logic              out_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [7:0]        instr_count
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(LAST_ADDR);

    state_e              state_q, state_d;
    logic [ProgW-1:0]    prog_q, prog_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [InstrW-1:0]   ir_q, ir_d;
    strobes_t            strb_q, strb_d;
    logic                error_q, error_d;
    logic [7:0]          count_q, count_d;

    strobes_t            dec_strobes;
    logic                dec_illegal;

    eight_bit_decoder u_decoder (
        .ir      (ir_q),
        .strobes (dec_strobes),
        .illegal (dec_illegal)
    );

    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
        error_d = error_q;
        count_d = count_q;
        // Strobes drop to zero in every state except a held (stalled) EXEC
        strb_d  = '0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    prog_d  = prog_sel;
                    addr_d  = '0;
                    error_d = 1'b0;
                    count_d = '0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                ir_d    = instruction;
                state_d = StDecode;
            end
            StDecode: begin
                if (dec_illegal) begin
                    error_d = 1'b1;
                    state_d = StDone;
                end else begin
                    strb_d  = dec_strobes;
                    state_d = StExec;
                end
            end
            StExec: begin
                if (!exec_ready) begin
                    strb_d = strb_q;
                end else begin
                    if (count_q != 8'hFF) begin
                        count_d = count_q + 8'd1;
                    end
                    if (strb_q.out) begin
                        state_d = StDone;
                    end else if (addr_q == LastAddr) begin
                        // Ran off the end of the program without an `out`
                        error_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            prog_q  <= '0;
            addr_q  <= '0;
            ir_q    <= '0;
            strb_q  <= '0;
            error_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            prog_q  <= prog_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
            strb_q  <= strb_d;
            error_q <= error_d;
            count_q <= count_d;
        end
    end

    assign prog        = prog_q;
    assign address     = addr_q;
    assign alu_en      = strb_q.alu;
    assign load_a_en   = strb_q.load_a;
    assign load_b_en   = strb_q.load_b;
    assign push_en     = strb_q.push;
    assign out_en      = strb_q.out;
    assign alu_op      = strb_q.alu ? opcode_of(ir_q) : '0;
    assign ra          = ir_q[RaHi:RaLo];
    assign rb          = ir_q[RbHi:RbLo];
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone) && !error_q;
    assign error       = error_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_eight_bit_sequencer.sv
// Directed testbench for eight_bit_sequencer. A second instance with
// LAST_ADDR=5 exercises the address-overrun path.
module tb_eight_bit_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start, exec_ready;
    logic [1:0] prog_sel, prog;
    logic [7:0] address, instruction, instr_count;
    logic       alu_en, load_a_en, load_b_en, push_en, out_en, busy, done, error;
    logic [3:0] alu_op;
    logic [1:0] ra, rb;
    logic [4:0] stb;

    logic       start2;
    logic [1:0] prog_sel2, prog2;
    logic [7:0] address2, instruction2, instr_count2;
    logic       alu_en2, load_a_en2, load_b_en2, push_en2, out_en2, busy2, done2, error2;
    logic [3:0] alu_op2;
    logic [1:0] ra2, rb2;

    int total = 0;
    int bad   = 0;

    // Program 3 expected EXEC view: {alu,lda,ldb,push,out}, alu_op, ra, rb
    logic [4:0] exp_stb [13] = '{5'b01000, 5'b00100, 5'b10000, 5'b00010, 5'b10000,
                                 5'b00010, 5'b10000, 5'b00010, 5'b10000, 5'b00010,
                                 5'b10000, 5'b00010, 5'b00001};
    logic [3:0] exp_op  [13] = '{4'h0, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h7, 4'h0,
                                 4'hD, 4'h0, 4'h1, 4'h0, 4'h0};
    logic [1:0] exp_ra  [13] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2,
                                 2'd0, 2'd3, 2'd0, 2'd0, 2'd2};
    logic [1:0] exp_rb  [13] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                                 2'd0, 2'd0, 2'd3, 2'd0, 2'd0};

    // prog 3: lda ldb sqa push shr push sqb push bshr push sub push out
    // prog 0: lda ldb <illegal E0>
    function automatic logic [7:0] rom(input logic [1:0] p, input logic [7:0] a);
        logic [7:0] r;
        r = 8'hB0;
        if (p == 2'd3) begin
            case (a)
                8'd0:  r = 8'h90;
                8'd1:  r = 8'hA4;
                8'd2:  r = 8'h60;
                8'd3:  r = 8'h80;
                8'd4:  r = 8'hC0;
                8'd5:  r = 8'h84;
                8'd6:  r = 8'h70;
                8'd7:  r = 8'h88;
                8'd8:  r = 8'hD0;
                8'd9:  r = 8'h8C;
                8'd10: r = 8'h13;
                8'd11: r = 8'h80;
                default: r = 8'hB8;
            endcase
        end else if (p == 2'd0) begin
            case (a)
                8'd0:  r = 8'h90;
                8'd1:  r = 8'hA0;
                default: r = 8'hE0;
            endcase
        end
        return r;
    endfunction

    assign instruction = rom(prog, address);
    assign stb = {alu_en, load_a_en, load_b_en, push_en, out_en};

    eight_bit_sequencer #(.ADDR_W(8), .LAST_ADDR(255)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prog_sel(prog_sel), .prog(prog),
        .address(address), .instruction(instruction), .exec_ready(exec_ready),
        .alu_en(alu_en), .alu_op(alu_op), .ra(ra), .rb(rb), .load_a_en(load_a_en),
        .load_b_en(load_b_en), .push_en(push_en), .out_en(out_en), .busy(busy),
        .done(done), .error(error), .instr_count(instr_count)
    );

    eight_bit_sequencer #(.ADDR_W(8), .LAST_ADDR(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .prog_sel(prog_sel2), .prog(prog2),
        .address(address2), .instruction(instruction2), .exec_ready(1'b1),
        .alu_en(alu_en2), .alu_op(alu_op2), .ra(ra2), .rb(rb2), .load_a_en(load_a_en2),
        .load_b_en(load_b_en2), .push_en(push_en2), .out_en(out_en2), .busy(busy2),
        .done(done2), .error(error2), .instr_count(instr_count2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge; returns in cycle 1 of the run
    task automatic kick(input logic [1:0] sel);
        start    = 1'b1;
        prog_sel = sel;
        step();
        start    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++;
        if ({stb, alu_op, address, prog, busy, done, error, instr_count, ra, rb} !== '0) begin
            bad++;
            $display("FAIL reset_dut1 got=%h want=0",
                     {stb, alu_op, address, prog, busy, done, error, instr_count, ra, rb});
        end
        total++;
        if ({alu_en2, load_a_en2, load_b_en2, push_en2, out_en2, alu_op2, address2, prog2,
             busy2, done2, error2, instr_count2, ra2, rb2} !== '0) begin
            bad++;
            $display("FAIL reset_dut2 got=%h want=0",
                     {alu_en2, load_a_en2, load_b_en2, push_en2, out_en2, alu_op2, address2,
                      prog2, busy2, done2, error2, instr_count2, ra2, rb2});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // Full run of program 3, optionally stalling the sqa EXEC (cycles 9..12)
    // and/or re-pulsing start with a different prog_sel mid-run.
    task automatic run_prog3(input string tag, input bit stall, input bit repulse);
        int         e;
        int         idx;
        logic [4:0] want_stb;
        logic [3:0] want_op;
        logic [7:0] want_addr;
        kick(2'd3);
        for (int c = 1; c <= 45; c++) begin
            if (stall && c >= 13)     e = c - 4;
            else if (stall && c >= 9) e = 9;
            else                      e = c;
            want_addr = (e <= 39) ? 8'((e - 1) / 3) : 8'd12;
            want_stb  = '0;
            want_op   = '0;
            if (e <= 39 && (e % 3) == 0) begin
                idx      = e / 3 - 1;
                want_stb = exp_stb[idx];
                want_op  = exp_op[idx];
                total++;
                if ({ra, rb} !== {exp_ra[idx], exp_rb[idx]}) begin
                    bad++;
                    $display("FAIL %s_rarb c=%0d got=%b want=%b", tag, c, {ra, rb},
                             {exp_ra[idx], exp_rb[idx]});
                end
            end
            total++;
            if (stb !== want_stb) begin
                bad++;
                $display("FAIL %s_strobe c=%0d got=%b want=%b", tag, c, stb, want_stb);
            end
            total++;
            if (alu_op !== want_op) begin
                bad++;
                $display("FAIL %s_alu_op c=%0d got=%h want=%h", tag, c, alu_op, want_op);
            end
            total++;
            if (address !== want_addr) begin
                bad++;
                $display("FAIL %s_address c=%0d got=%0d want=%0d", tag, c, address, want_addr);
            end
            total++;
            if ({done, busy, error, prog} !== {e == 40, e <= 40, 1'b0, 2'd3}) begin
                bad++;
                $display("FAIL %s_status c=%0d done/busy/err/prog got=%b want=%b", tag, c,
                         {done, busy, error, prog}, {e == 40, e <= 40, 1'b0, 2'd3});
            end
            exec_ready = !(stall && c >= 9 && c <= 12);
            start      = repulse && (c == 5 || c == 20);
            prog_sel   = start ? 2'd1 : 2'd3;
            step();
        end
        start      = 1'b0;
        exec_ready = 1'b1;
        total++;
        if (instr_count !== 8'd13) begin
            bad++;
            $display("FAIL %s_count got=%0d want=13", tag, instr_count);
        end
    endtask

    task automatic test_program3();
        run_prog3("prog3", 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        run_prog3("stall", 1'b1, 1'b0);
    endtask

    task automatic test_illegal();
        logic [4:0] want_stb;
        logic [7:0] want_addr;
        kick(2'd0);
        for (int c = 1; c <= 10; c++) begin
            want_stb  = (c == 3) ? 5'b01000 : (c == 6) ? 5'b00100 : 5'b00000;
            want_addr = (c <= 3) ? 8'd0 : (c <= 6) ? 8'd1 : 8'd2;
            total++;
            if (stb !== want_stb) begin
                bad++;
                $display("FAIL illegal_strobe c=%0d got=%b want=%b", c, stb, want_stb);
            end
            total++;
            if (address !== want_addr) begin
                bad++;
                $display("FAIL illegal_address c=%0d got=%0d want=%0d", c, address, want_addr);
            end
            total++;
            if ({done, busy, error} !== {1'b0, c <= 9, c >= 9}) begin
                bad++;
                $display("FAIL illegal_status c=%0d done/busy/err got=%b want=%b", c,
                         {done, busy, error}, {1'b0, c <= 9, c >= 9});
            end
            step();
        end
        total++;
        if (instr_count !== 8'd2) begin
            bad++;
            $display("FAIL illegal_count got=%0d want=2", instr_count);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] want_addr;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            want_addr = (c <= 18) ? 8'((c - 1) / 3) : 8'd5;
            total++;
            if (alu_en2 !== ((c % 3) == 0 && c <= 18)) begin
                bad++;
                $display("FAIL overrun_alu_en c=%0d got=%b", c, alu_en2);
            end
            total++;
            if (address2 !== want_addr) begin
                bad++;
                $display("FAIL overrun_address c=%0d got=%0d want=%0d", c, address2, want_addr);
            end
            total++;
            if ({done2, busy2, error2} !== {1'b0, c <= 19, c >= 19}) begin
                bad++;
                $display("FAIL overrun_status c=%0d done/busy/err got=%b want=%b", c,
                         {done2, busy2, error2}, {1'b0, c <= 19, c >= 19});
            end
            step();
        end
        total++;
        if (instr_count2 !== 8'd6) begin
            bad++;
            $display("FAIL overrun_count got=%0d want=6", instr_count2);
        end
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        total++;
        if ({error2, busy2, address2, instr_count2} !== {1'b0, 1'b1, 8'd0, 8'd0}) begin
            bad++;
            $display("FAIL overrun_restart err/busy/addr/cnt got=%h want=%h",
                     {error2, busy2, address2, instr_count2}, {1'b0, 1'b1, 8'd0, 8'd0});
        end
        repeat (22) step();
    endtask

    task automatic test_reset_mid_run();
        kick(2'd3);
        repeat (14) step();
        // Cycle 15: EXEC of address 4 (shr)
        total++;
        if ({alu_en, alu_op, address} !== {1'b1, 4'hC, 8'd4}) begin
            bad++;
            $display("FAIL midrst_pre got=%h want=%h", {alu_en, alu_op, address},
                     {1'b1, 4'hC, 8'd4});
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({stb, alu_op, address, prog, busy, done, error, instr_count, ra, rb} !== '0) begin
            bad++;
            $display("FAIL midrst_outputs got=%h want=0",
                     {stb, alu_op, address, prog, busy, done, error, instr_count, ra, rb});
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_prog3("after_rst", 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_prog3("repulse", 1'b0, 1'b1);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        prog_sel     = 2'd0;
        exec_ready   = 1'b1;
        start2       = 1'b0;
        prog_sel2    = 2'd1;
        instruction2 = 8'h00;
        test_reset();
        test_program3();
        test_stall();
        test_illegal();
        test_overrun();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
